game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 128 ++++++++++++
 tb/tb_game_state_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow controller: start, lives, score and timed respawn/wave/game-over phases
module game_state_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 120,
  parameter int WAVE_FRAMES    = 60,
  parameter int OVER_FRAMES    = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start,
  input  logic       alien_hit,
  input  logic       player_hit,
  input  logic       aliens_cleared,
  input  logic       invaded,
  output logic       play_en,
  output logic       wave_reset,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    RESPAWN   = 3'd2,
    WAVE_CLR  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_LD = 2'(LIVES_INIT);
  localparam logic [7:0] RESP_N   = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] WAVE_N   = 8'(WAVE_FRAMES);
  localparam logic [7:0] OVER_N   = 8'(OVER_FRAMES);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt, cnt_d, cnt_inc, score_d, high_d;
  logic [1:0] lives_d;
  logic       wave_d, start_prev, start_armed, start_edge;

  assign state   = state_q;
  assign cnt_inc = frame_cnt + 8'd1;
  // start_armed keeps a button held through reset from counting as a fresh press
  assign start_edge = refresh_tick & start & ~start_prev & start_armed;

  always_comb begin
    state_d = state_q;
    lives_d = lives;
    score_d = score;
    high_d  = high_score;
    cnt_d   = frame_cnt;
    wave_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = PLAYING;
          lives_d = LIVES_LD;
          score_d = 8'd0;
          wave_d  = 1'b1;
        end
      end
      PLAYING: begin
        cnt_d = 8'd0;
        if (alien_hit && score != 8'hFF) score_d = score + 8'd1;
        if (invaded) begin
          state_d = GAME_OVER;
          lives_d = 2'd0;
        end else if (player_hit) begin
          lives_d = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          state_d = (lives <= 2'd1) ? GAME_OVER : RESPAWN;
        end else if (aliens_cleared) begin
          state_d = WAVE_CLR;
        end
        if (state_d == GAME_OVER && score_d > high_score) high_d = score_d;
      end
      RESPAWN: begin
        if (refresh_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == RESP_N) state_d = PLAYING;
        end
      end
      WAVE_CLR: begin
        if (refresh_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == WAVE_N) begin
            state_d = PLAYING;
            wave_d  = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (refresh_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == OVER_N) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lives       <= 2'd0;
      score       <= 8'd0;
      high_score  <= 8'd0;
      frame_cnt   <= 8'd0;
      play_en     <= 1'b0;
      wave_reset  <= 1'b0;
      start_prev  <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives      <= lives_d;
      score      <= score_d;
      high_score <= high_d;
      frame_cnt  <= cnt_d;
      play_en    <= (state_d == PLAYING);
      wave_reset <= wave_d;
      if (refresh_tick) begin
        start_prev <= start;
        if (!start) start_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - randomized bench for game_state_ctrl against a frame-level game model
module tb_game_state_ctrl;
  localparam int LI = 3, RF = 120, WF = 60, OF = 180;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0, start = 1'b0, alien_hit = 1'b0;
  logic       player_hit = 1'b0, aliens_cleared = 1'b0, invaded = 1'b0;
  logic       play_en, wave_reset;
  logic [1:0] lives;
  logic [7:0] score, high_score;
  logic [2:0] state;

  int n_cmp = 0, n_err = 0;
  int n;

  typedef struct {
    int st, lv, sc, hs, left;
    bit prev, armed, wave;
  } mdl_t;
  mdl_t m;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .LIVES_INIT(LI), .RESPAWN_FRAMES(RF), .WAVE_FRAMES(WF), .OVER_FRAMES(OF)
  ) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
    .alien_hit(alien_hit), .player_hit(player_hit), .aliens_cleared(aliens_cleared),
    .invaded(invaded), .play_en(play_en), .wave_reset(wave_reset), .lives(lives),
    .score(score), .high_score(high_score), .state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: states as plain numbers, timed phases as "frames left" countdowns
  function automatic mdl_t go_over(input mdl_t x);
    x.st = 4; x.lv = 0; x.left = OF;
    if (x.sc > x.hs) x.hs = x.sc;
    return x;
  endfunction

  function automatic mdl_t step(input mdl_t x);
    bit press;
    press = refresh_tick && start && !x.prev && x.armed;
    x.wave = 0;
    case (x.st)
      0: if (press) begin x.st = 1; x.lv = LI; x.sc = 0; x.wave = 1; end
      1: begin
        if (alien_hit) x.sc = (x.sc < 255) ? x.sc + 1 : 255;
        if (invaded) x = go_over(x);
        else if (player_hit) begin
          x.lv = x.lv - 1;
          if (x.lv == 0) x = go_over(x);
          else begin x.st = 2; x.left = RF; end
        end else if (aliens_cleared) begin x.st = 3; x.left = WF; end
      end
      default: if (refresh_tick) begin
        x.left = x.left - 1;
        if (x.left == 0) begin
          x.wave = (x.st == 3);
          x.st = (x.st == 4) ? 0 : 1;
        end
      end
    endcase
    if (refresh_tick) begin
      x.prev = start;
      if (!start) x.armed = 1;
    end
    return x;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{default: 0};
    else m <= step(m);
  end

  always @(negedge clk) begin
    check("state", int'(state), m.st);
    check("lives", int'(lives), m.lv);
    check("score", int'(score), m.sc);
    check("high_score", int'(high_score), m.hs);
    check("play_en", int'(play_en), int'(m.st == 1));
    check("wave_reset", int'(wave_reset), int'(m.wave));
  end

  task automatic cyc(input logic tk, input logic ah, input logic ph, input logic inv);
    refresh_tick = tk; alien_hit = ah; player_hit = ph; invaded = inv;
    @(negedge clk);
    refresh_tick = 1'b0; alien_hit = 1'b0; player_hit = 1'b0; invaded = 1'b0;
  endtask

  task automatic frame();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int k);
    repeat (k) frame();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_lives"}, int'(lives), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_hs"}, int'(high_score), 0);
    check({tag, "_play"}, int'(play_en), 0);
    check({tag, "_wave"}, int'(wave_reset), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    frames(2);
    check("idle_hold", int'(state), 0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_score", int'(score), 0);

    start = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_state", int'(state), 1);
    check("start_lives", int'(lives), 3);
    check("start_score", int'(score), 0);
    check("start_wave", int'(wave_reset), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("start_wave_end", int'(wave_reset), 0);
    start = 1'b0;

    repeat (9) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("score9", int'(score), 9);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("prio_state", int'(state), 4);
    check("prio_lives", int'(lives), 0);
    check("prio_score", int'(score), 10);
    check("prio_hs", int'(high_score), 10);
    frames(OF - 1);
    check("over_hold", int'(state), 4);
    frame();
    check("over_exit", int'(state), 0);
    check("over_score_held", int'(score), 10);

    start = 1'b1; frame(); start = 1'b0;
    check("b_start", int'(state), 1);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    aliens_cleared = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    aliens_cleared = 1'b0;
    check("wave_state", int'(state), 3);
    frames(WF - 1);
    check("wave_hold", int'(state), 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("wave_exit", int'(state), 1);
    check("wave_pulse", int'(wave_reset), 1);
    check("wave_lives", int'(lives), 3);
    check("wave_score", int'(score), 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("wave_pulse_end", int'(wave_reset), 0);

    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("hit%0d_lives", k), int'(lives), 2 - k);
      check($sformatf("hit%0d_state", k), int'(state), (k < 2) ? 2 : 4);
      if (k < 2) begin
        n = 0;
        while (!play_en && n < 300) begin frame(); n++; end
        check($sformatf("respawn%0d_frames", k), n, RF);
      end
    end

    start = 1'b1;
    frames(OF + 5);
    check("held_start_idle", int'(state), 0);
    start = 1'b0; frame(); start = 1'b1; frame();
    check("repress_start", int'(state), 1);

    repeat (300) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sat", int'(score), 255);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("sat_hold", int'(score), 255);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("inv_state", int'(state), 4);
    check("inv_hs", int'(high_score), 255);
    frames(10);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    frames(5);
    check("midrst_hold", int'(state), 0);
    start = 1'b0; frame(); start = 1'b1; frame();
    check("midrst_restart", int'(state), 1);

    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 49) == 0) start = ~start;
      if ($urandom_range(0, 29) == 0) aliens_cleared = ~aliens_cleared;
      reset = ($urandom_range(0, 3999) == 0);
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
    end
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
